kpd_scan: RTL



---
 rtl/kpd_scan_if.sv | 11 +
 rtl/kpd_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/kpd_scan_if.sv
// Keypad-side and key-report signals of the scanner; master is the scanner, slave is the keypad/consumer.
interface kpd_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;

  modport master (input row, output col, key, key_valid, key_down);
  modport slave  (output row, input col, key, key_valid, key_down);
endinterface

// File: rtl/kpd_scan.sv
// 4x4 keypad scanner: 2**N-cycle column dwell, frame debounce over D frames; outputs update the cycle
// after the last column sample. Free-running with no backpressure; key_valid is a single-cycle pulse.
module kpd_scan #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic       clk,
  input  logic       rst,
  kpd_scan_if.master kp
);
  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;

  localparam int SW = $clog2(D + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(D);

  logic [3:0]    row_meta, row_sync;
  logic [N-1:0]  ctr;
  logic [1:0]    idx;
  logic [15:0]   acc;
  res_t          prev_kind;
  logic [3:0]    prev_code;
  logic [SW-1:0] stab;
  logic [3:0]    key_q;
  logic          key_valid_q, key_down_q;

  logic          sample, frame_end;
  logic [15:0]   frame;
  logic [4:0]    hits;
  logic [3:0]    hit_pos;
  res_t          r_kind;
  logic [3:0]    r_code;
  logic          same;
  logic [SW-1:0] stab_nxt;
  logic          accept, key_rel;

  // Position is {column, row}; returns the legend printed on that key.
  function automatic logic [3:0] key_at(input logic [3:0] pos);
    case (pos)
      4'd0:  key_at = 4'h1;
      4'd1:  key_at = 4'h4;
      4'd2:  key_at = 4'h7;
      4'd3:  key_at = 4'h0;
      4'd4:  key_at = 4'h2;
      4'd5:  key_at = 4'h5;
      4'd6:  key_at = 4'h8;
      4'd7:  key_at = 4'hF;
      4'd8:  key_at = 4'h3;
      4'd9:  key_at = 4'h6;
      4'd10: key_at = 4'h9;
      4'd11: key_at = 4'hE;
      4'd12: key_at = 4'hA;
      4'd13: key_at = 4'hB;
      4'd14: key_at = 4'hC;
      default: key_at = 4'hD;
    endcase
  endfunction

  always_comb begin
    sample    = (ctr == '1);
    frame_end = sample && (idx == 2'd3);
    frame     = acc | ({12'd0, ~row_sync} << {idx, 2'b00});
    hits      = 5'd0;
    hit_pos   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        hits    = hits + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  // Code is forced to zero for NONE/MULTI so equal results compare equal.
  always_comb begin
    r_kind = RES_MULTI;
    r_code = 4'd0;
    if (hits == 5'd0) begin
      r_kind = RES_NONE;
    end else if (hits == 5'd1) begin
      r_kind = RES_KEY;
      r_code = key_at(hit_pos);
    end
    same     = (r_kind == prev_kind) && (r_code == prev_code);
    stab_nxt = same ? ((stab == STAB_MAX) ? stab : stab + SW'(1)) : SW'(1);
    accept   = frame_end && (stab_nxt == STAB_MAX) && (r_kind == RES_KEY) &&
               (!key_down_q || (key_q != r_code));
    key_rel  = frame_end && (stab_nxt == STAB_MAX) && (r_kind == RES_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      ctr         <= '0;
      idx         <= 2'd0;
      acc         <= 16'd0;
      prev_kind   <= RES_NONE;
      prev_code   <= 4'd0;
      stab        <= '0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
      ctr      <= ctr + N'(1);
      if (sample) idx <= idx + 2'd1;
      if (frame_end) begin
        acc       <= 16'd0;
        prev_kind <= r_kind;
        prev_code <= r_code;
        stab      <= stab_nxt;
      end else if (sample) begin
        acc <= frame;
      end
      key_valid_q <= accept;
      if (accept) begin
        key_q      <= r_code;
        key_down_q <= 1'b1;
      end else if (key_rel) begin
        key_down_q <= 1'b0;
      end
    end
  end

  assign kp.col       = ~(4'b0001 << idx);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
endmodule
